// File: rtl/gemv_pkg.sv
// Shared definitions for the GEMV weight-tile path.
// Holds the default element/tile/beat geometry, the controller and fetch
// state encodings, and the tile type shared with the GEMV engine.
package gemv_pkg;

  localparam int GEMV_DATA_WIDTH = 8;
  localparam int GEMV_TILE_SIZE  = 32;
  localparam int GEMV_BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_DONE = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_END  = 2'd2
  } fetch_state_e;

  typedef logic signed [GEMV_DATA_WIDTH-1:0] tile_t [GEMV_TILE_SIZE];

endpackage

// File: rtl/tile_buffer.sv
// Two-entry tile FIFO feeding the GEMV engine.
// Beats are written straight into the tail entry; the first beat of a tile
// clears the whole entry so that elements never written stay zero, and lanes
// at or beyond the tile's element count are written as zero.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   beat_we_i/first/off/n    beat write: lane k -> element off+k, zeroed if >= n
//   beat_data_i              BEAT_BYTES packed elements, lane 0 in the low byte
//   commit_i + sideband      close the tail tile with {row, last_in_row, last}
//   pop_i                    drop the head entry (ignored while empty)
//   full_o, empty_o          occupancy flags
//   head_*_o                 head entry tile and sideband
module tile_buffer
  import gemv_pkg::*;
#(
  parameter int DATA_WIDTH = GEMV_DATA_WIDTH,
  parameter int TILE_SIZE  = GEMV_TILE_SIZE,
  parameter int BEAT_BYTES = GEMV_BEAT_BYTES,
  parameter int DIM_W      = 11,
  parameter int OFF_W      = 6
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             beat_we_i,
  input  logic                             beat_first_i,
  input  logic [OFF_W-1:0]                 beat_off_i,
  input  logic [OFF_W-1:0]                 beat_n_i,
  input  logic [BEAT_BYTES*DATA_WIDTH-1:0] beat_data_i,
  input  logic                             commit_i,
  input  logic [DIM_W-1:0]                 commit_row_i,
  input  logic                             commit_last_in_row_i,
  input  logic                             commit_last_i,
  input  logic                             pop_i,
  output logic                             full_o,
  output logic                             empty_o,
  output logic signed [DATA_WIDTH-1:0]     head_tile_o [TILE_SIZE],
  output logic [DIM_W-1:0]                 head_row_o,
  output logic                             head_last_in_row_o,
  output logic                             head_last_o
);

  logic [DATA_WIDTH-1:0] tile_q [2][TILE_SIZE];
  logic [DIM_W-1:0]      row_q  [2];
  logic [1:0]            lir_q;
  logic [1:0]            last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  pop_eff;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign pop_eff = pop_i && !empty_o;
  // Commit and pop in the same cycle leave occupancy unchanged.
  assign count_d = count_q + {1'b0, commit_i} - {1'b0, pop_eff};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (commit_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_eff)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < 2; s++) begin
        for (int e = 0; e < TILE_SIZE; e++) tile_q[s][e] <= '0;
        row_q[s] <= '0;
      end
      lir_q  <= '0;
      last_q <= '0;
    end else begin
      if (beat_we_i) begin
        if (beat_first_i) begin
          for (int e = 0; e < TILE_SIZE; e++) tile_q[wr_ptr_q][e] <= '0;
        end
        for (int k = 0; k < BEAT_BYTES; k++) begin
          tile_q[wr_ptr_q][int'(beat_off_i) + k] <=
            (int'(beat_off_i) + k < int'(beat_n_i)) ? beat_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
      end
      if (commit_i) begin
        row_q[wr_ptr_q]  <= commit_row_i;
        lir_q[wr_ptr_q]  <= commit_last_in_row_i;
        last_q[wr_ptr_q] <= commit_last_i;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < TILE_SIZE; e++) head_tile_o[e] = tile_q[rd_ptr_q][e];
    head_row_o         = row_q[rd_ptr_q];
    head_last_in_row_o = lir_q[rd_ptr_q];
    head_last_o        = last_q[rd_ptr_q];
  end

endmodule

// File: rtl/gemv_tile_scheduler.sv
// Weight-tile fetch scheduler for the tiled GEMV engine.
// On start it walks a row-major INT8 matrix, issuing one beat read at a time,
// assembles zero-padded tiles into a two-entry buffer and presents them on a
// valid/ready port.
// Handshake: a tile transfers on a cycle where w_valid && w_ready; the head tile
// and its sideband hold while w_valid=1 and w_ready=0; w_ready with w_valid=0
// does nothing.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   start, base_addr, rows, cols     matrix request, latched in IDLE
//   busy, done                       RUN indicator, one-cycle completion pulse
//   mem_rd_en, mem_addr              beat read request
//   mem_rd_valid, mem_rd_data        beat read response (byte k = addr+k)
//   w_tile, w_valid, w_ready         head tile handshake
//   tile_row, tile_last_in_row,
//   tile_last                        head tile sideband
//   dbg_ctrl_state, dbg_fetch_state  FSM state observation
module gemv_tile_scheduler
  import gemv_pkg::*;
#(
  parameter int  DATA_WIDTH  = GEMV_DATA_WIDTH,
  parameter int  TILE_SIZE   = GEMV_TILE_SIZE,
  parameter int  BEAT_BYTES  = GEMV_BEAT_BYTES,
  parameter int  ADDR_WIDTH  = 24,
  parameter int  MAX_ROWS    = 1024,
  parameter int  MAX_COLUMNS = 1024,
  localparam int DIM_W       = $clog2(MAX_ROWS + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [DIM_W-1:0]                 rows,
  input  logic [DIM_W-1:0]                 cols,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_rd_valid,
  input  logic [BEAT_BYTES*DATA_WIDTH-1:0] mem_rd_data,
  output logic signed [DATA_WIDTH-1:0]     w_tile [TILE_SIZE],
  output logic                             w_valid,
  input  logic                             w_ready,
  output logic [DIM_W-1:0]                 tile_row,
  output logic                             tile_last_in_row,
  output logic                             tile_last,
  output logic [1:0]                       dbg_ctrl_state,
  output logic [1:0]                       dbg_fetch_state
);

  localparam int OFF_W  = $clog2(TILE_SIZE + 1);
  localparam int BOFF_W = OFF_W + 1;
  localparam int CSUM_W = $clog2(MAX_COLUMNS + TILE_SIZE + 1);

  ctrl_state_e  ctrl_q, ctrl_d;
  fetch_state_e fetch_q, fetch_d;

  logic [DIM_W-1:0]      rows_q, cols_q, row_q, col_start_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [OFF_W-1:0]      beat_off_q;

  logic [DIM_W-1:0] rem;
  logic [OFF_W-1:0] tile_n;
  logic             last_beat, last_in_row, last_row;
  logic             beat_we, commit, buf_full, buf_empty;

  // Tile geometry for the tile currently being fetched.
  assign rem         = cols_q - col_start_q;
  assign tile_n      = (rem >= DIM_W'(TILE_SIZE)) ? OFF_W'(TILE_SIZE) : OFF_W'(rem);
  assign last_beat   = (BOFF_W'(beat_off_q) + BOFF_W'(BEAT_BYTES)) >= BOFF_W'(tile_n);
  assign last_in_row = (CSUM_W'(col_start_q) + CSUM_W'(TILE_SIZE)) >= CSUM_W'(cols_q);
  assign last_row    = (row_q == rows_q - DIM_W'(1));
  assign mem_addr    = row_base_q + ADDR_WIDTH'(col_start_q) + ADDR_WIDTH'(beat_off_q);

  assign w_valid         = !buf_empty;
  assign dbg_ctrl_state  = ctrl_q;
  assign dbg_fetch_state = fetch_q;

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= C_IDLE;
      fetch_q <= F_REQ;
    end else begin
      ctrl_q  <= ctrl_d;
      fetch_q <= fetch_d;
    end
  end

  // Next-state logic
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      C_IDLE: if (start) ctrl_d = (rows == '0 || cols == '0) ? C_DONE : C_RUN;
      C_RUN:  if (w_valid && w_ready && tile_last) ctrl_d = C_DONE;
      C_DONE: ctrl_d = C_IDLE;
      default: ctrl_d = C_IDLE;
    endcase
  end

  always_comb begin
    fetch_d = fetch_q;
    if (ctrl_q != C_RUN) begin
      fetch_d = F_REQ;
    end else begin
      case (fetch_q)
        F_REQ:  if (!buf_full) fetch_d = F_WAIT;
        F_WAIT: if (mem_rd_valid) fetch_d = (last_beat && last_in_row && last_row) ? F_END : F_REQ;
        F_END:  fetch_d = F_END;
        default: fetch_d = F_REQ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (ctrl_q == C_RUN);
    done      = (ctrl_q == C_DONE);
    mem_rd_en = (ctrl_q == C_RUN) && (fetch_q == F_REQ) && !buf_full;
    // Responses are only taken while a read is outstanding.
    beat_we   = (ctrl_q == C_RUN) && (fetch_q == F_WAIT) && mem_rd_valid;
    commit    = beat_we && last_beat;
  end

  // Walk counters; row_base advances by cols per row so no multiplier is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_start_q <= '0;
      row_base_q  <= '0;
      beat_off_q  <= '0;
    end else if (ctrl_q == C_IDLE) begin
      if (start) begin
        rows_q      <= rows;
        cols_q      <= cols;
        row_base_q  <= base_addr;
        row_q       <= '0;
        col_start_q <= '0;
        beat_off_q  <= '0;
      end
    end else if (beat_we) begin
      if (commit) begin
        beat_off_q <= '0;
        if (last_in_row) begin
          row_q       <= row_q + DIM_W'(1);
          row_base_q  <= row_base_q + ADDR_WIDTH'(cols_q);
          col_start_q <= '0;
        end else begin
          col_start_q <= col_start_q + DIM_W'(TILE_SIZE);
        end
      end else begin
        beat_off_q <= beat_off_q + OFF_W'(BEAT_BYTES);
      end
    end
  end

  tile_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_SIZE  (TILE_SIZE),
    .BEAT_BYTES (BEAT_BYTES),
    .DIM_W      (DIM_W),
    .OFF_W      (OFF_W)
  ) u_buf (
    .clk_i                (clk),
    .rst_ni               (reset_n),
    .beat_we_i            (beat_we),
    .beat_first_i         (beat_off_q == '0),
    .beat_off_i           (beat_off_q),
    .beat_n_i             (tile_n),
    .beat_data_i          (mem_rd_data),
    .commit_i             (commit),
    .commit_row_i         (row_q),
    .commit_last_in_row_i (last_in_row),
    .commit_last_i        (last_in_row && last_row),
    .pop_i                (w_valid && w_ready),
    .full_o               (buf_full),
    .empty_o              (buf_empty),
    .head_tile_o          (w_tile),
    .head_row_o           (tile_row),
    .head_last_in_row_o   (tile_last_in_row),
    .head_last_o          (tile_last)
  );

endmodule
